// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the 4-instruction CPU: opcodes, sequencer states, field positions.
// Used by the fetch/sequencing unit and its instruction memory.
package cpu_defs;

    localparam logic [1:0] OP_RTYPE = 2'b00;
    localparam logic [1:0] OP_LW    = 2'b01;
    localparam logic [1:0] OP_SW    = 2'b10;
    localparam logic [1:0] OP_BEQ   = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FETCH  = 2'b01,
        DECODE = 2'b10,
        EXEC   = 2'b11
    } state_t;

    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 6;
    localparam int RS_MSB  = 5;
    localparam int RS_LSB  = 4;
    localparam int RT_MSB  = 3;
    localparam int RT_LSB  = 2;
    localparam int IMM_MSB = 1;
    localparam int IMM_LSB = 0;

    function automatic logic is_beq(input logic [1:0] op);
        return op == OP_BEQ;
    endfunction

endpackage

// File: rtl/imem.sv
// Instruction memory: one write port, one registered read port whose output register is the IR.
// The read register clears synchronously so the IR resets to zero while the array itself keeps its contents.
module imem #(
    parameter int AW = 4,
    parameter int IW = 8
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    logic [IW-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_fetch_seq.sv
// Fetch/sequencing unit: PC, IR and a FETCH-DECODE-EXEC phase FSM, 3 cycles per instruction.
// Program load is only accepted while halted; Step runs one instruction from IDLE.
module instr_fetch_seq
    import cpu_defs::*;
#(
    parameter int AW = 4,
    parameter int IW = 8,
    parameter int DW = 8
) (
    input  logic          Clk,
    input  logic          Clear,
    input  logic          Run,
    input  logic          Step,
    input  logic          LoadEn,
    input  logic [AW-1:0] LoadAddr,
    input  logic [IW-1:0] LoadData,
    input  logic          BranchTaken,
    output logic [1:0]    Op,
    output logic [1:0]    Rs,
    output logic [1:0]    Rt,
    output logic [1:0]    Rd,
    output logic [DW-1:0] Imm,
    output logic [AW-1:0] PC,
    output logic          ExecStrobe,
    output logic          Halted
);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] pc_nxt;
    logic [AW-1:0] imm_pc;
    logic [IW-1:0] ir;
    logic          fetch_en;
    logic          load_we;

    imem #(
        .AW(AW),
        .IW(IW)
    ) u_imem (
        .clk   (Clk),
        .clear (Clear),
        .we    (load_we),
        .waddr (LoadAddr),
        .wdata (LoadData),
        .re    (fetch_en),
        .raddr (PC),
        .rdata (ir)
    );

    // IR only changes on the FETCH->DECODE edge, so fields hold steady through EXEC.
    assign Op     = ir[OP_MSB:OP_LSB];
    assign Rs     = ir[RS_MSB:RS_LSB];
    assign Rt     = ir[RT_MSB:RT_LSB];
    assign Rd     = ir[IMM_MSB:IMM_LSB];
    assign Imm    = {{(DW-2){ir[IMM_MSB]}}, ir[IMM_MSB:IMM_LSB]};
    assign imm_pc = {{(AW-2){ir[IMM_MSB]}}, ir[IMM_MSB:IMM_LSB]};

    // Clear in EXEC must suppress the commit in that same cycle.
    assign ExecStrobe = (state == EXEC) && !Clear;
    assign Halted     = (state == IDLE);

    always_comb begin
        state_nxt = state;
        pc_nxt    = PC;
        fetch_en  = 1'b0;
        load_we   = 1'b0;
        case (state)
            IDLE: begin
                load_we = LoadEn && !Clear;
                if (Run || Step) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                fetch_en  = 1'b1;
                state_nxt = DECODE;
            end
            DECODE: begin
                state_nxt = EXEC;
            end
            EXEC: begin
                if (BranchTaken && is_beq(Op)) begin
                    pc_nxt = PC + AW'(1) + imm_pc;
                end else begin
                    pc_nxt = PC + AW'(1);
                end
                state_nxt = Run ? FETCH : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Clear) begin
            state <= IDLE;
            PC    <= '0;
        end else begin
            state <= state_nxt;
            PC    <= pc_nxt;
        end
    end

endmodule
